// File: rtl/test_card_sequencer.sv
// Picks the active test card; changes commit only on the frame-start pulse.
// TEST_CARD_SEQ_BLANK_EN inserts one black frame between cards (o_blank).
module test_card_sequencer #(
    parameter int NUM_CARDS       = 3,
    parameter int SEL_W           = 2,
    parameter int AUTO_FRAMES     = 300,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic             i_pix_clk,
    input  logic             i_rst,
    input  logic             i_frame,
    input  logic             i_btn_next,
    input  logic             i_auto,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_sel_changed,
    output logic             o_pending,
    output logic             o_blank
);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int AC_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [AC_W-1:0]  AC_LAST  = AC_W'(AUTO_FRAMES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_CARDS - 1);

    typedef enum logic [1:0] {IDLE, PENDING, BLANK} state_t;

    state_t            state_q, state_d;
    logic              btn_meta_q, btn_sync_q;
    logic              db_q, db_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [AC_W-1:0]   auto_q, auto_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              chg_q, chg_d;
    logic              db_match, db_flip, req, auto_due, adv, upd;

    // Debounce: the synchronised level must disagree for DEBOUNCE_CYCLES clocks.
    always_comb begin
        db_match = (btn_sync_q == db_q);
        db_flip  = !db_match && (db_cnt_q == DB_LAST);
        db_d     = db_q ^ db_flip;
        db_cnt_d = (db_match || db_flip) ? '0 : db_cnt_q + 1'b1;
        req      = db_flip && !db_q;
        auto_due = i_auto && i_frame && (auto_q == AC_LAST);
    end

    always_comb begin
        state_d = state_q;
        adv     = 1'b0;
        upd     = 1'b0;
        case (state_q)
            IDLE: begin
                if ((req && i_frame) || auto_due) adv = 1'b1;
                else if (req)                     state_d = PENDING;
            end
            PENDING: if (i_frame) adv = 1'b1;
`ifdef TEST_CARD_SEQ_BLANK_EN
            BLANK: begin
                if (i_frame) begin
                    upd     = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        if (adv) begin
`ifdef TEST_CARD_SEQ_BLANK_EN
            state_d = BLANK;
`else
            upd     = 1'b1;
            state_d = IDLE;
`endif
        end
        sel_d = sel_q;
        chg_d = upd;
        if (upd) sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
        // Auto count freezes from the advance decision until o_sel actually moves.
        auto_d = auto_q;
        if (!i_auto)                        auto_d = '0;
        else if (upd)                       auto_d = '0;
        else if (adv || state_q == BLANK)   auto_d = auto_q;
        else if (i_frame)                   auto_d = auto_q + 1'b1;
    end

    always_ff @(posedge i_pix_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= IDLE;
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            db_q       <= 1'b0;
            db_cnt_q   <= '0;
            auto_q     <= '0;
            sel_q      <= '0;
            chg_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            btn_meta_q <= i_btn_next;
            btn_sync_q <= btn_meta_q;
            db_q       <= db_d;
            db_cnt_q   <= db_cnt_d;
            auto_q     <= auto_d;
            sel_q      <= sel_d;
            chg_q      <= chg_d;
        end
    end

    assign o_sel         = sel_q;
    assign o_sel_changed = chg_q;
    assign o_pending     = (state_q == PENDING);
`ifdef TEST_CARD_SEQ_BLANK_EN
    assign o_blank       = (state_q == BLANK);
`else
    assign o_blank       = 1'b0;
`endif
endmodule

// File: tb/tb_test_card_sequencer.sv
// Bench for test_card_sequencer: directed scenarios plus random button/auto
// traffic against a frame-level reference model.
module tb_test_card_sequencer;
    localparam int NC = 3, SW = 2, AF = 3, DB = 4, PER = 100;

    logic          clk = 1'b0, rst_n = 1'b0, frame = 1'b0, btn = 1'b0, auto_en = 1'b0;
    logic [SW-1:0] o_sel;
    logic          o_sel_changed, o_pending, o_blank;

    test_card_sequencer #(.NUM_CARDS(NC), .SEL_W(SW), .AUTO_FRAMES(AF), .DEBOUNCE_CYCLES(DB)) dut (
        .i_pix_clk(clk), .i_rst(rst_n), .i_frame(frame), .i_btn_next(btn), .i_auto(auto_en),
        .o_sel(o_sel), .o_sel_changed(o_sel_changed), .o_pending(o_pending), .o_blank(o_blank));

    always #5 clk = ~clk;

    int errors = 0, checks = 0, phase = 0, chg_seen = 0, steps = 0;

    // Reference model: card index, pending flag, frames shown in auto mode,
    // and a window of raw button samples (a press is a run of DB equal samples
    // seen two clocks late through the synchroniser).
    int m_sel, m_frames;
    bit m_pend, m_chg, m_db;
    bit hist[DB+2];

    task automatic model_reset();
        m_sel = 0; m_frames = 0; m_pend = 0; m_chg = 0; m_db = 0;
        for (int i = 0; i < DB + 2; i++) hist[i] = 0;
    endtask

    task automatic model_edge();
        bit toggle, press, adv;
        for (int i = DB + 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = btn;
        toggle = 1;
        for (int i = 2; i <= DB + 1; i++) if (hist[i] == m_db) toggle = 0;
        press = toggle && !m_db;
        if (toggle) m_db = !m_db;
        adv   = frame && (m_pend || press || (auto_en && m_frames == AF - 1));
        m_chg = adv;
        if (adv) begin
            m_sel  = (m_sel + 1) % NC;
            m_pend = 0;
        end else if (press) m_pend = 1;
        if (!auto_en || adv) m_frames = 0;
        else if (frame)      m_frames++;
    endtask

    task automatic step();
        frame = (phase == PER - 1);
        @(posedge clk);
        if (!rst_n) model_reset(); else model_edge();
        phase = (phase + 1) % PER;
        steps++;
        #1;
        if (o_sel_changed === 1'b1) chg_seen++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (o_sel !== '0 || o_pending !== 1'b0 || o_sel_changed !== 1'b0 || o_blank !== 1'b0) begin
            errors++; $display("FAIL reset_state sel=%0d pend=%0b chg=%0b blank=%0b want all 0", o_sel, o_pending, o_sel_changed, o_blank);
        end
        model_reset();
        step(); step();
        rst_n = 1'b1;
        chg_seen = 0;
        for (int i = 0; i < 5 * PER; i++) begin
            step();
            checks++;
            if (o_sel !== m_sel[SW-1:0] || o_pending !== m_pend || o_sel_changed !== m_chg || o_blank !== 1'b0) begin
                errors++; $display("FAIL idle_frames t=%0t sel=%0d want %0d pend=%0b want %0b chg=%0b want %0b", $time, o_sel, m_sel, o_pending, m_pend, o_sel_changed, m_chg);
            end
        end
        checks++;
        if (chg_seen != 0 || o_sel !== 2'd0) begin
            errors++; $display("FAIL idle_no_change changes=%0d sel=%0d want 0 and 0", chg_seen, o_sel);
        end
    endtask

    task automatic test_manual();
        while (phase != 50) step();
        btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++;
            if (o_sel !== m_sel[SW-1:0] || o_pending !== m_pend || o_sel_changed !== m_chg) begin
                errors++; $display("FAIL manual_press t=%0t sel=%0d want %0d pend=%0b want %0b chg=%0b want %0b", $time, o_sel, m_sel, o_pending, m_pend, o_sel_changed, m_chg);
            end
            if (i == 5 || i == 6) begin
                checks++;
                if (o_pending !== (i == 6)) begin
                    errors++; $display("FAIL pending_latency clk=%0d pend=%0b want %0b", i, o_pending, (i == 6));
                end
            end
        end
        btn = 1'b0;
        chg_seen = 0;
        while (phase != 10) begin
            step();
            checks++;
            if (o_sel !== m_sel[SW-1:0] || o_pending !== m_pend || o_sel_changed !== m_chg) begin
                errors++; $display("FAIL manual_commit t=%0t sel=%0d want %0d pend=%0b want %0b chg=%0b want %0b", $time, o_sel, m_sel, o_pending, m_pend, o_sel_changed, m_chg);
            end
        end
        checks++;
        if (o_sel !== 2'd1 || chg_seen != 1 || o_pending !== 1'b0) begin
            errors++; $display("FAIL manual_result sel=%0d changes=%0d pend=%0b want 1,1,0", o_sel, chg_seen, o_pending);
        end
    endtask

    task automatic test_glitch();
        int s0, pend_seen;
        s0 = m_sel; pend_seen = 0; chg_seen = 0;
        while (phase != 20) step();
        for (int i = 0; i < 40; i++) begin
            if (i < 2)       btn = 1'b1;
            else if (i < 12) btn = 1'b0;
            else if (i < 32) btn = i[0];
            else             btn = 1'b0;
            step();
            if (o_pending === 1'b1) pend_seen++;
            checks++;
            if (o_sel !== m_sel[SW-1:0] || o_pending !== m_pend || o_sel_changed !== m_chg) begin
                errors++; $display("FAIL glitch t=%0t sel=%0d want %0d pend=%0b want %0b chg=%0b want %0b", $time, o_sel, m_sel, o_pending, m_pend, o_sel_changed, m_chg);
            end
        end
        while (phase != 10) step();
        checks++;
        if (o_sel !== s0[SW-1:0] || chg_seen != 0 || pend_seen != 0) begin
            errors++; $display("FAIL glitch_result sel=%0d want %0d changes=%0d pend_cycles=%0d want 0", o_sel, s0, chg_seen, pend_seen);
        end
    endtask

    task automatic test_auto();
        do_reset();
        while (phase != 50) step();
        auto_en = 1'b1;
        chg_seen = 0;
        for (int i = 0; i < 10 * PER; i++) begin
            step();
            checks++;
            if (o_sel !== m_sel[SW-1:0] || o_pending !== m_pend || o_sel_changed !== m_chg) begin
                errors++; $display("FAIL auto t=%0t sel=%0d want %0d chg=%0b want %0b", $time, o_sel, m_sel, o_sel_changed, m_chg);
            end
        end
        auto_en = 1'b0;
        checks++;
        if (chg_seen != 3 || o_sel !== 2'd0) begin
            errors++; $display("FAIL auto_wrap changes=%0d sel=%0d want 3 and 0", chg_seen, o_sel);
        end
    endtask

    task automatic test_manual_auto();
        int first_chg;
        do_reset();
        while (phase != 50) step();
        auto_en = 1'b1;
        for (int i = 0; i < 2 * PER; i++) step();
        btn = 1'b1;
        for (int i = 0; i < 10; i++) step();
        btn = 1'b0;
        checks++;
        if (o_pending !== 1'b1) begin
            errors++; $display("FAIL combo_pending pend=%0b want 1", o_pending);
        end
        chg_seen = 0;
        while (phase != 10) begin
            step();
            checks++;
            if (o_sel !== m_sel[SW-1:0] || o_pending !== m_pend || o_sel_changed !== m_chg) begin
                errors++; $display("FAIL combo t=%0t sel=%0d want %0d pend=%0b want %0b chg=%0b want %0b", $time, o_sel, m_sel, o_pending, m_pend, o_sel_changed, m_chg);
            end
        end
        checks++;
        if (chg_seen != 1 || o_sel !== 2'd1) begin
            errors++; $display("FAIL combo_single changes=%0d sel=%0d want 1 and 1", chg_seen, o_sel);
        end
        chg_seen = 0; first_chg = -1;
        for (int i = 1; i <= 3 * PER; i++) begin
            step();
            if (o_sel_changed === 1'b1 && first_chg < 0) first_chg = i;
        end
        auto_en = 1'b0;
        checks++;
        if (first_chg != 290 || chg_seen != 1 || o_sel !== 2'd2) begin
            errors++; $display("FAIL combo_restart first_change=%0d changes=%0d sel=%0d want 290,1,2", first_chg, chg_seen, o_sel);
        end
    endtask

    task automatic test_random();
        int len;
        for (int seg = 0; seg < 400; seg++) begin
            btn = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) auto_en = ~auto_en;
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                step();
                checks++;
                if (o_sel !== m_sel[SW-1:0] || o_pending !== m_pend || o_sel_changed !== m_chg || o_blank !== 1'b0) begin
                    errors++; $display("FAIL random t=%0t sel=%0d want %0d pend=%0b want %0b chg=%0b want %0b", $time, o_sel, m_sel, o_pending, m_pend, o_sel_changed, m_chg);
                end
            end
        end
        btn = 1'b0; auto_en = 1'b0;
    endtask

    task automatic test_reset_pending();
        while (phase != 30) step();
        btn = 1'b1;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (o_pending !== 1'b1) begin
            errors++; $display("FAIL rst_pend_setup pend=%0b want 1", o_pending);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (o_sel !== '0 || o_pending !== 1'b0 || o_sel_changed !== 1'b0 || o_blank !== 1'b0) begin
            errors++; $display("FAIL rst_async sel=%0d pend=%0b chg=%0b blank=%0b want all 0", o_sel, o_pending, o_sel_changed, o_blank);
        end
        btn = 1'b0;
        step(); step(); step();
        rst_n = 1'b1;
        chg_seen = 0;
        for (int i = 0; i < 2; i++) begin
            do step(); while (phase != 10);
        end
        checks++;
        if (chg_seen != 0 || o_sel !== 2'd0 || o_pending !== 1'b0) begin
            errors++; $display("FAIL rst_discard changes=%0d sel=%0d pend=%0b want 0,0,0", chg_seen, o_sel, o_pending);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_manual();
        test_glitch();
        test_auto();
        test_manual_auto();
        test_random();
        test_reset_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/test_card_sequencer.md
Name: test_card_sequencer

Overview:
- Selects which test card drives the display datapath, one card per frame, for the display demo top levels.
- Takes a raw push-button ("next card") and an optional auto-advance mode.
- Commits every change only on the frame-start pulse from display_timings, so a card never switches mid-frame.
- Drives the select input of the test card mux in the demo top level.

Parameters:
- NUM_CARDS, 3, number of test cards; o_sel counts 0..NUM_CARDS-1 and then wraps; must be >= 2.
- SEL_W, 2, width of o_sel; must satisfy 2^SEL_W >= NUM_CARDS.
- AUTO_FRAMES, 300, frames each card is shown in auto mode; must be >= 1.
- DEBOUNCE_CYCLES, 250000, pixel clocks the synchronised button must be stable before it is accepted; must be >= 1.

Ports:
- i_pix_clk  input  1  pixel clock; all logic is on its rising edge.
- i_rst  input  1  reset, asynchronous assert, active-low.
- i_frame  input  1  single-cycle frame-start pulse from display_timings.
- i_btn_next  input  1  raw, asynchronous, active-high "next card" button.
- i_auto  input  1  level; when high, auto-advance is enabled.
- o_sel  output  SEL_W  current card select (registered).
- o_sel_changed  output  1  one-cycle pulse in the cycle o_sel takes a new value.
- o_pending  output  1  a manual advance is latched and waiting for i_frame.
- o_blank  output  1  force black output (used only by the optional feature).

Behaviour:
- Reset (i_rst low, asynchronous): all outputs 0, all counters 0, debounced button state 0, FSM in IDLE.
- Reset mid-operation discards any pending request and any blank in progress.
- Button synchroniser: two-flop synchroniser on i_btn_next.
- Debounce:
  - The counter counts while the synchronised level differs from the debounced state, and clears to 0 when they match.
  - When the count reaches DEBOUNCE_CYCLES-1, the debounced state toggles and the counter clears.
  - A 0->1 transition of the debounced state produces a one-cycle internal request, req.
- Auto counter:
  - While i_auto is low, it is held at 0.
  - While i_auto is high, it increments on each i_frame.
  - auto_due = i_auto & i_frame & (count == AUTO_FRAMES-1).
  - The counter clears on any committed advance, including a manual one.
- FSM states: IDLE, PENDING.
- IDLE:
  - req with i_frame low: go to PENDING, o_pending=1.
  - req in the same cycle as i_frame: advance immediately.
  - auto_due: advance.
- PENDING:
  - Further req pulses are ignored; there is no queue, so at most one advance per frame.
  - On i_frame: advance, return to IDLE, o_pending=0.
- Advance:
  - o_sel <= (o_sel == NUM_CARDS-1) ? 0 : o_sel+1, committed on the clock edge that samples i_frame high.
  - o_sel_changed is high for exactly that following cycle.
  - Latency is one clock from i_frame.
- Simultaneous manual and auto on the same i_frame: a single advance, one o_sel_changed pulse, and the auto counter clears.
- i_auto falling while PENDING: the manual request is still honoured at the next i_frame.
- o_sel never changes in a cycle without a sampled i_frame, except at reset.

Optional Feature:
- Macro: TEST_CARD_SEQ_BLANK_EN.
- Defined:
  - Adds an FSM state BLANK.
  - An advance does not update o_sel directly. Instead, at that i_frame it sets o_blank=1 and the FSM enters BLANK.
  - At the next i_frame: o_sel advances, o_sel_changed pulses, o_blank=0, and the FSM goes to IDLE. Exactly one full black frame separates cards.
  - req during BLANK is ignored.
  - The auto counter is held during BLANK and clears when o_sel updates.
- Not defined: no BLANK state and o_blank is tied to 0.

Test Plan (NUM_CARDS=3, AUTO_FRAMES=3, DEBOUNCE_CYCLES=4, i_frame every 100 clocks):
- Reset release, no stimulus, 5 frames -> o_sel=0, o_pending=0, o_sel_changed never asserted.
- i_btn_next high for 10 clocks mid-frame -> o_pending=1 about 6 clocks later (2 sync + 4 debounce); at the next i_frame o_sel 0->1 one clock later; one o_sel_changed pulse; o_pending=0.
- i_btn_next high for only 2 clocks (glitch), and bouncing 1/0 every clock -> no request, o_sel unchanged.
- i_auto=1 for 10 frames -> o_sel advances every 3rd i_frame: 0,1,2,0 wrap; exactly one o_sel_changed per advance.
- i_auto=1, manual press accepted so it is pending on the frame where auto_due fires -> single advance 1->2, auto count restarts, next auto advance 3 frames later.
- Reset asserted while o_pending=1 (and, with TEST_CARD_SEQ_BLANK_EN, while o_blank=1) -> all outputs 0 immediately; after release the next i_frame causes no advance.
